// File: rtl/lcm_if.sv
// lcm_if: operand/result handshake bundle for lcm_unit.
//   in_valid/in_ready  : operand triple (in_a, in_b, gcd_in) handshake
//   out_valid/out_ready: result (lcm, zero, err) handshake
// master drives operands and out_ready; slave (lcm_unit) drives the rest.
interface lcm_if #(parameter int unsigned WIDTH = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     gcd_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   lcm;
  logic                 zero;
  logic                 err;

  modport master (
    output in_valid, in_a, in_b, gcd_in, out_ready,
    input  in_ready, out_valid, lcm, zero, err
  );

  modport slave (
    input  in_valid, in_a, in_b, gcd_in, out_ready,
    output in_ready, out_valid, lcm, zero, err
  );
endinterface

// File: rtl/lcm_unit.sv
// lcm_unit: sequential LCM stage fed by a combinational GCD block.
// Computes lcm = (a / g) * b with a WIDTH-cycle restoring divider followed by
// a WIDTH-cycle shift-add multiplier, and flags g == 0 or g not dividing a.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lcm_if.slave (operand in, result out, valid/ready both ways)
module lcm_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  lcm_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     g_q, g_d;
  logic [WIDTH-1:0]     quo_q, quo_d;      // dividend, then quotient, then multiplier
  logic [WIDTH:0]       rem_q, rem_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;  // b, shifted left once per MUL cycle
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   lcm_q, lcm_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_sub;
  logic                 rem_ge;
  logic                 last;

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, g_q};
    rem_ge    = (rem_shift >= {1'b0, g_q});
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    lcm_d   = lcm_q;
    zero_d  = zero_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          g_d     = bus.gcd_in;
          quo_d   = bus.in_a;
          mcand_d = {{WIDTH{1'b0}}, bus.in_b};
          cnt_d   = '0;
          rem_d   = '0;
          acc_d   = '0;
          if (bus.in_a == '0 || bus.in_b == '0) begin
            state_d = DONE;
            lcm_d   = '0;
            zero_d  = 1'b1;
            err_d   = 1'b0;
          end else if (bus.gcd_in == '0) begin
            state_d = DONE;
            lcm_d   = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end

      DIV: begin
        // Quotient bits shift in at the LSB as dividend bits leave at the MSB.
        if (rem_ge) begin
          rem_d = rem_sub;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d = '0;
          if (rem_d != '0) begin
            state_d = DONE;
            lcm_d   = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = MUL;
            acc_d   = '0;
          end
        end
      end

      MUL: begin
        if (quo_q[0]) acc_d = acc_q + mcand_q;
        quo_d   = quo_q >> 1;
        mcand_d = mcand_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          lcm_d   = acc_d;
          zero_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      g_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      lcm_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      lcm_q   <= lcm_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.lcm       = lcm_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lcm_unit.sv
// tb_lcm_unit: scoreboard bench for lcm_unit. The stimulus side pushes the
// expected result of each accepted triple; a monitor pops and compares when
// out_valid rises and keeps comparing while the result is held.
// Latency counts the accepting edge as edge 1.
module tb_lcm_unit;
  localparam int unsigned W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lcm_if #(.WIDTH(W)) bus ();

  lcm_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint unsigned lcm;
    bit              zero;
    bit              err;
    int              lat;
    longint          acc_cyc;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  bit     auto_rdy = 1'b0;
  bit     rand_bp  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int unsigned gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: the arithmetic definition of the result, independent of cycles.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned g);
    exp_t e;
    e.acc_cyc = 0;
    e.lcm  = 0;
    e.zero = 1'b0;
    e.err  = 1'b0;
    if (a == 0 || b == 0) begin
      e.zero = 1'b1;
      e.lat  = 1;
    end else if (g == 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (a % g != 0) begin
      e.err = 1'b1;
      e.lat = W + 1;
    end else begin
      e.lcm = 64'(a / g) * 64'(b);
      e.lat = 2 * W + 1;
    end
    return e;
  endfunction

  // Called right after a negedge; returns at a negedge after acceptance.
  task automatic issue(input int unsigned a, input int unsigned b, input int unsigned g,
                       output int edges);
    exp_t e;
    bit   r;
    bus.in_a     = a[W-1:0];
    bus.in_b     = b[W-1:0];
    bus.gcd_in   = g[W-1:0];
    bus.in_valid = 1'b1;
    edges = 0;
    for (int k = 0; k < 400; k++) begin
      r = bus.in_ready;
      @(posedge clk);
      edges++;
      #1;
      if (r) begin
        e = model(a, b, g);
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: got no accept, expected accept within 400 edges");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
  endtask

  // Consumer
  initial begin
    forever begin
      @(negedge clk);
      if (auto_rdy) bus.out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  initial begin
    exp_t cur;
    bit   have;
    logic pv;
    have = 1'b0;
    pv   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv   = 1'b0;
        have = 1'b0;
        continue;
      end
      if (bus.out_valid === 1'b1 && !pv) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          have = 1'b0;
          $display("FAIL unexpected_result: got lcm=%0d, expected no output", bus.lcm);
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
          chk("latency", 64'(cyc - cur.acc_cyc + 1), 64'(cur.lat));
        end
      end
      if (bus.out_valid === 1'b1 && have) begin
        chk("lcm",  64'(bus.lcm),  cur.lcm);
        chk("zero", 64'(bus.zero), 64'(cur.zero));
        chk("err",  64'(bus.err),  64'(cur.err));
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
      end
      pv = bus.out_valid;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  int unsigned da[7] = '{12, 32'hFFFF, 32'hFFFF, 0, 0, 10, 5};
  int unsigned db[7] = '{18, 32'hFFFE, 32'hFFFF, 7, 0, 4,  9};
  int unsigned dg[7] = '{6,  1,        32'hFFFF, 7, 0, 3,  0};

  initial begin
    int ed;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.gcd_in    = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_lcm",       64'(bus.lcm),       64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    auto_rdy = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(da[i], db[i], dg[i], ed);
      drain();
    end

    // Backpressure: hold result, wiggle inputs, then release.
    auto_rdy = 1'b0;
    bus.out_ready = 1'b0;
    issue(12, 18, 6, ed);
    for (int k = 0; k < 100; k++) begin
      if (bus.out_valid === 1'b1) break;
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      bus.in_a     = 16'd3;
      bus.in_b     = 16'd3;
      bus.gcd_in   = 16'd1;
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    issue(7, 5, 1, ed);
    chk("bp_accept_edges", 64'(ed), 64'd2);
    drain();
    auto_rdy = 1'b1;

    // Random phase with random consumer stalls.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int unsigned a, b, g, m;
      m = $urandom_range(0, 9);
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      if (m < 4) begin
        a = a & 32'h00FF;
        b = b & 32'h00FF;
      end
      g = gcd(a, b);
      if (m == 6) a = 0;
      if (m == 7) b = 0;
      if (m == 8) g = $urandom_range(1, 65535);
      if (m == 9) g = 0;
      issue(a, b, g, ed);
    end
    drain();
    rand_bp = 1'b0;

    // Asynchronous reset mid-division.
    issue(9, 6, 3, ed);
    drain();
    issue(100, 75, 25, ed);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_lcm",       64'(bus.lcm),       64'd0);
    chk("arst_zero",      64'(bus.zero),      64'd0);
    chk("arst_err",       64'(bus.err),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4, 6, 2, ed);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcm_unit.md
Name: lcm_unit

Overview:
- Sequential least-common-multiple stage, placed directly downstream of the combinational 16-bit GCD block.
- Captures operands A and B together with the GCD block's result for those same operands.
- Computes LCM = (A / G) * B with a multi-cycle restoring divider followed by a shift-add multiplier.
- Returns the 2*WIDTH-bit result through a valid/ready handshake. Also cross-checks that G actually divides A.

Parameters:
- WIDTH, 16, operand and GCD width; the result is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand triple is valid.
- in_ready  output  1  block can accept a triple (high only in IDLE).
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- gcd_in  input  WIDTH  GCD block output for in_a/in_b, sampled in the same cycle.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- lcm  output  2*WIDTH  result, unsigned.
- zero  output  1  an operand was 0; lcm = 0.
- err  output  1  gcd_in was 0 or did not divide in_a; lcm = 0.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - in_ready = 1; out_valid = 0; lcm = 0; zero = 0; err = 0.
  - Internal registers and counter cleared.
  - Asserting reset mid-operation aborts the computation immediately; no output is produced for the aborted triple.
- States: IDLE, DIV, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On a rising edge with in_valid = 1, capture a = in_a, b = in_b, g = gcd_in.
  - If a == 0 or b == 0: go to DONE with lcm = 0, zero = 1, err = 0. This takes priority over the error check.
  - Else if g == 0: go to DONE with lcm = 0, err = 1.
  - Otherwise: go to DIV with cnt = 0, remainder = 0, quotient = a.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first, exactly WIDTH cycles.
  - Remainder register is WIDTH+1 bits to absorb the shift.
  - After the last iteration:
    - Remainder != 0: go to DONE with lcm = 0, err = 1.
    - Remainder == 0: go to MUL with cnt = 0 and accumulator = 0.
- MUL:
  - Shift-add of quotient x b, one multiplier bit per cycle (LSB first), exactly WIDTH cycles.
  - Accumulator is 2*WIDTH bits and cannot overflow, since quotient*b <= a*b < 2^(2*WIDTH).
  - After the last iteration, go to DONE with lcm = accumulator, zero = 0, err = 0.
- DONE:
  - out_valid = 1; lcm, zero and err are held stable.
  - in_ready = 0 throughout.
  - On a rising edge with out_ready = 1: go to IDLE and clear out_valid.
  - lcm, zero and err keep their value until the next result is loaded.
- Latency, counted from the accepting edge to the edge on which out_valid rises:
  - Normal path: 2*WIDTH+1 edges (33 for WIDTH = 16).
  - Zero or g == 0 path: 1 edge.
  - Divisibility-error path: WIDTH+1 edges.
- Throughput:
  - in_ready is low from the accepting edge until the result is taken.
  - in_valid/in_a/in_b/gcd_in are ignored while busy.
  - No new triple is accepted on the same edge that out_ready completes DONE.
  - The earliest next accept is one edge later; max one result per 2*WIDTH+2 cycles.
- out_ready is ignored outside DONE. in_valid may remain high continuously.

Test Plan:
- a=12, b=18, g=6 -> out_valid exactly 33 edges after accept; lcm = 36; zero = 0; err = 0.
- a=0xFFFF, b=0xFFFE, g=1 -> lcm = 0xFFFD0002 (4294770690). Repeat with a=0xFFFF, b=0xFFFF, g=0xFFFF -> lcm = 0x0000FFFF.
- a=0, b=7, g=7 -> out_valid 1 edge after accept; lcm = 0; zero = 1. Then a=0, b=0, g=0 -> zero = 1, err = 0.
- a=10, b=4, g=3 -> out_valid 17 edges after accept; lcm = 0; err = 1. Then a=5, b=9, g=0 -> err = 1 after 1 edge.
- Backpressure: result 36 pending with out_ready low for 5 cycles:
  - lcm, zero and err stay stable; in_ready stays 0; new in_valid is ignored.
  - Raise out_ready -> next triple (7, 5, 1) is accepted one edge after the release and yields lcm = 35.
- Reset: deassert rst_n asynchronously at DIV cycle 8 -> all outputs return immediately to reset values with no clock edge.
  - After release, triple (4, 6, 2) yields lcm = 12 with normal latency.
